// File: rtl/ext_mem_l2_arbiter_pkg.sv
// Shared constants for the L2 front-end arbiter: FSM state encodings and master indices.
package ext_mem_l2_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;
  localparam logic [1:0] ST_INV   = 2'd3;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

endpackage

// File: rtl/ext_mem_l2_arb_sel.sv
// Tie-break for the two back-end masters; grant choice is one-hot, indexed by MST_I/MST_D.
// Build option EXT_MEM_L2_ARB_RR_EN selects round-robin, otherwise dcache wins ties.
module ext_mem_l2_arb_sel
  import ext_mem_l2_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cke_i,
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       done_i,
  input  logic       done_mst_i,
  output logic [1:0] gnt_o
);

  logic winner;

`ifdef EXT_MEM_L2_ARB_RR_EN
  logic favor_q;

  // The favoured master flips to whichever one did not own the completed transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      favor_q <= MST_D;
    end else if (cke_i && done_i) begin
      favor_q <= ~done_mst_i;
    end
  end

  assign winner = favor_q;
`else
  logic unused_rr;
  assign unused_rr = ^{clk_i, rst_i, cke_i, done_i, done_mst_i};
  assign winner    = MST_D;
`endif

  always_comb begin
    gnt_o = '0;
    if (i_req_i && d_req_i) begin
      gnt_o[winner] = 1'b1;
    end else if (d_req_i) begin
      gnt_o[MST_D] = 1'b1;
    end else if (i_req_i) begin
      gnt_o[MST_I] = 1'b1;
    end
  end

endmodule

// File: rtl/ext_mem_l2_arbiter.sv
// Arbitrates icache/dcache back-end IOb buses onto the L2 front-end and sequences L2 invalidation.
// Optional round-robin tie-break via EXT_MEM_L2_ARB_RR_EN (see ext_mem_l2_arb_sel).
module ext_mem_l2_arbiter
  import ext_mem_l2_arbiter_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  input  logic [DATA_W-1:0]   i_wdata_i,
  input  logic [DATA_W/8-1:0] i_wstrb_i,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_ack_o,
  input  logic                d_req_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wstrb_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_ack_o,
  input  logic                inv_i,
  output logic                s_req_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_ack_i,
  output logic                s_inv_o,
  output logic                inv_busy_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       inv_pend_q;
  logic       inv_pend_d;
  logic       enter_inv;
  logic [1:0] gnt;
  logic       done;
  logic       done_mst;

  assign done     = cke_i & s_ack_i & ((state_q == ST_GNT_I) | (state_q == ST_GNT_D));
  assign done_mst = (state_q == ST_GNT_D) ? MST_D : MST_I;

  ext_mem_l2_arb_sel u_sel (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cke_i      (cke_i),
    .i_req_i    (i_req_i),
    .d_req_i    (d_req_i),
    .done_i     (done),
    .done_mst_i (done_mst),
    .gnt_o      (gnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (inv_pend_q) begin
          state_d = ST_INV;
        end else if (gnt[MST_D]) begin
          state_d = ST_GNT_D;
        end else if (gnt[MST_I]) begin
          state_d = ST_GNT_I;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (s_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending invalidate is consumed on entry to INV; pulses while already pending merge into it.
  assign enter_inv  = (state_q == ST_IDLE) & inv_pend_q;
  assign inv_pend_d = enter_inv ? 1'b0 : (inv_pend_q | inv_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      inv_pend_q <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  always_comb begin
    s_req_o   = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    i_ack_o   = 1'b0;
    d_ack_o   = 1'b0;
    case (state_q)
      ST_GNT_I: begin
        s_req_o   = i_req_i;
        s_addr_o  = i_addr_i;
        s_wdata_o = i_wdata_i;
        s_wstrb_o = i_wstrb_i;
        i_ack_o   = s_ack_i;
      end
      ST_GNT_D: begin
        s_req_o   = d_req_i;
        s_addr_o  = d_addr_i;
        s_wdata_o = d_wdata_i;
        s_wstrb_o = d_wstrb_i;
        d_ack_o   = s_ack_i;
      end
      default: begin
      end
    endcase
  end

  assign i_rdata_o  = s_rdata_i;
  assign d_rdata_o  = s_rdata_i;
  assign s_inv_o    = (state_q == ST_INV);
  assign inv_busy_o = inv_pend_q | s_inv_o;

endmodule

// File: tb/tb_ext_mem_l2_arbiter.sv
// Self-checking bench for ext_mem_l2_arbiter; honours EXT_MEM_L2_ARB_RR_EN like the DUT.
module tb_ext_mem_l2_arbiter;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk_i;
  logic          rst_i;
  logic          cke_i;
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic [DW-1:0] i_wdata_i;
  logic [SW-1:0] i_wstrb_i;
  logic [DW-1:0] i_rdata_o;
  logic          i_ack_o;
  logic          d_req_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [SW-1:0] d_wstrb_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_ack_o;
  logic          inv_i;
  logic          s_req_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o;
  logic [SW-1:0] s_wstrb_o;
  logic [DW-1:0] s_rdata_i;
  logic          s_ack_i;
  logic          s_inv_o;
  logic          inv_busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_favor_d;

  ext_mem_l2_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cke_i(cke_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_wdata_i(i_wdata_i), .i_wstrb_i(i_wstrb_i),
    .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .inv_i(inv_i),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i), .s_inv_o(s_inv_o), .inv_busy_o(inv_busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // L2 must never see an invalidate and a request together.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      n_checks++;
      if (s_inv_o && s_req_o) begin
        n_fail++;
        $display("FAIL inv_req_overlap: s_inv_o=%b s_req_o=%b required not both 1", s_inv_o, s_req_o);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Which master the spec says wins when the given requests are pending in IDLE.
  function automatic bit model_pick_d(bit ir, bit dr);
    if (ir && dr) begin
`ifdef EXT_MEM_L2_ARB_RR_EN
      return model_favor_d;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  task automatic test_reset();
    logic [DW-1:0] rd;
    rst_i = 1'b1; cke_i = 1'b1; inv_i = 1'b0; s_ack_i = 1'b0;
    i_req_i = 1'b0; i_addr_i = '0; i_wdata_i = '0; i_wstrb_i = '0;
    d_req_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wstrb_i = '0;
    s_rdata_i = '0;
    repeat (3) step();
    rd = DW'($urandom);
    s_rdata_i = rd;
    #1;
    n_checks++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_sreq: got %b exp 0", s_req_o); end
    n_checks++; if (s_inv_o !== 1'b0) begin n_fail++; $display("FAIL rst_sinv: got %b exp 0", s_inv_o); end
    n_checks++; if (inv_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", inv_busy_o); end
    n_checks++; if ({i_ack_o, d_ack_o} !== 2'b00) begin n_fail++; $display("FAIL rst_acks: got %b exp 00", {i_ack_o, d_ack_o}); end
    n_checks++; if (s_addr_o !== '0) begin n_fail++; $display("FAIL rst_saddr: got %h exp 0", s_addr_o); end
    n_checks++; if (i_rdata_o !== rd || d_rdata_o !== rd) begin n_fail++; $display("FAIL rst_rdata: got %h/%h exp %h", i_rdata_o, d_rdata_o, rd); end
    rst_i = 1'b0;
    model_favor_d = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    i_req_i = 1'b1; i_addr_i = AW'(32'h100); i_wstrb_i = '0;
    #1;
    n_checks++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL rd_idle_sreq: got %b exp 0", s_req_o); end
    step(); #1;
    n_checks++; if (s_req_o !== 1'b1) begin n_fail++; $display("FAIL rd_sreq_lat: got %b exp 1", s_req_o); end
    n_checks++; if (s_addr_o !== AW'(32'h100)) begin n_fail++; $display("FAIL rd_saddr: got %h exp 100", s_addr_o); end
    n_checks++; if (s_wstrb_o !== '0) begin n_fail++; $display("FAIL rd_swstrb: got %h exp 0", s_wstrb_o); end
    step(); #1;
    n_checks++; if (i_ack_o !== 1'b0 || s_req_o !== 1'b1) begin n_fail++; $display("FAIL rd_wait: ack=%b sreq=%b exp 0/1", i_ack_o, s_req_o); end
    step();
    s_ack_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    #1;
    n_checks++; if (i_ack_o !== 1'b1) begin n_fail++; $display("FAIL rd_iack: got %b exp 1", i_ack_o); end
    n_checks++; if (i_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h exp deadbeef", i_rdata_o); end
    n_checks++; if (d_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_dack: got %b exp 0", d_ack_o); end
    step();
    s_ack_i = 1'b0; i_req_i = 1'b0;
    #1;
    n_checks++; if (s_req_o !== 1'b0 || i_ack_o !== 1'b0) begin n_fail++; $display("FAIL rd_after: sreq=%b iack=%b exp 0/0", s_req_o, i_ack_o); end
    model_favor_d = 1'b1;
    step();
  endtask

  task automatic test_simultaneous();
    bit exp_d;
    i_req_i = 1'b1; d_req_i = 1'b1;
    i_wstrb_i = '0; d_wstrb_i = '0;
    for (int k = 0; k < 4; k++) begin
      i_addr_i = AW'(32'h200 + k);
      d_addr_i = AW'(32'h300 + k);
`ifdef EXT_MEM_L2_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      step(); #1;
      n_checks++;
      if (s_addr_o !== (exp_d ? d_addr_i : i_addr_i)) begin
        n_fail++; $display("FAIL tie_winner[%0d]: got addr %h exp %h", k, s_addr_o, exp_d ? d_addr_i : i_addr_i);
      end
      step();
      s_ack_i = 1'b1; s_rdata_i = DW'($urandom);
      #1;
      n_checks++;
      if ({d_ack_o, i_ack_o} !== (exp_d ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL tie_ack[%0d]: got d/i %b exp %b", k, {d_ack_o, i_ack_o}, exp_d ? 2'b10 : 2'b01);
      end
      model_favor_d = !exp_d;
      step();
      s_ack_i = 1'b0;
      if (k == 3) begin i_req_i = 1'b0; d_req_i = 1'b0; end
      #1;
      n_checks++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL tie_idle[%0d]: sreq got %b exp 0", k, s_req_o); end
    end
    step();
  endtask

  task automatic test_random();
    int pat;
    int lat;
    bit wd;
    logic [DW-1:0] rd;
    for (int n = 0; n < 24; n++) begin
      pat = int'($urandom_range(1, 3));
      i_addr_i = AW'($urandom); i_wdata_i = DW'($urandom); i_wstrb_i = SW'($urandom);
      d_addr_i = AW'($urandom); d_wdata_i = DW'($urandom); d_wstrb_i = SW'($urandom);
      i_req_i = pat[0]; d_req_i = pat[1];
      wd = model_pick_d(pat[0], pat[1]);
      step(); #1;
      n_checks++;
      if (s_req_o !== 1'b1 || s_addr_o !== (wd ? d_addr_i : i_addr_i) || s_wdata_o !== (wd ? d_wdata_i : i_wdata_i)
          || s_wstrb_o !== (wd ? d_wstrb_i : i_wstrb_i)) begin
        n_fail++;
        $display("FAIL rnd_route[%0d]: got req=%b a=%h w=%h s=%h exp owner %s", n, s_req_o, s_addr_o, s_wdata_o, s_wstrb_o, wd ? "d" : "i");
      end
      lat = int'($urandom_range(0, 3));
      repeat (lat) step();
      rd = DW'($urandom);
      s_ack_i = 1'b1; s_rdata_i = rd;
      #1;
      n_checks++;
      if ({d_ack_o, i_ack_o} !== (wd ? 2'b10 : 2'b01) || (wd ? d_rdata_o : i_rdata_o) !== rd) begin
        n_fail++;
        $display("FAIL rnd_ack[%0d]: got d/i %b rdata %h exp %b %h", n, {d_ack_o, i_ack_o}, wd ? d_rdata_o : i_rdata_o, wd ? 2'b10 : 2'b01, rd);
      end
      model_favor_d = !wd;
      step();
      s_ack_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0;
      #1;
      n_checks++; if (s_req_o !== 1'b0) begin n_fail++; $display("FAIL rnd_idle[%0d]: sreq got %b exp 0", n, s_req_o); end
      step();
    end
  endtask

  task automatic test_inv_idle();
    inv_i = 1'b1;
    #1;
    n_checks++; if (s_inv_o !== 1'b0) begin n_fail++; $display("FAIL invi_c0: sinv got %b exp 0", s_inv_o); end
    step(); inv_i = 1'b0; #1;
    n_checks++; if (s_inv_o !== 1'b0 || inv_busy_o !== 1'b1) begin n_fail++; $display("FAIL invi_c1: sinv=%b busy=%b exp 0/1", s_inv_o, inv_busy_o); end
    step(); #1;
    n_checks++; if (s_inv_o !== 1'b1 || inv_busy_o !== 1'b1) begin n_fail++; $display("FAIL invi_c2: sinv=%b busy=%b exp 1/1", s_inv_o, inv_busy_o); end
    step(); #1;
    n_checks++; if (s_inv_o !== 1'b0 || inv_busy_o !== 1'b0) begin n_fail++; $display("FAIL invi_c3: sinv=%b busy=%b exp 0/0", s_inv_o, inv_busy_o); end
  endtask

  task automatic test_inv_during_write();
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    ia = AW'($urandom); da = AW'($urandom);
    d_req_i = 1'b1; d_addr_i = da; d_wdata_i = DW'($urandom); d_wstrb_i = 4'hF;
    step(); #1;
    n_checks++; if (s_req_o !== 1'b1 || s_wstrb_o !== 4'hF) begin n_fail++; $display("FAIL invw_gnt: sreq=%b wstrb=%h exp 1/f", s_req_o, s_wstrb_o); end
    inv_i = 1'b1; i_req_i = 1'b1; i_addr_i = ia; i_wstrb_i = '0;
    step(); inv_i = 1'b0; #1;
    n_checks++; if (inv_busy_o !== 1'b1 || s_inv_o !== 1'b0 || s_addr_o !== da) begin n_fail++; $display("FAIL invw_hold: busy=%b sinv=%b addr=%h exp 1/0/%h", inv_busy_o, s_inv_o, s_addr_o, da); end
    step();
    s_ack_i = 1'b1; #1;
    n_checks++; if (d_ack_o !== 1'b1 || i_ack_o !== 1'b0 || s_inv_o !== 1'b0) begin n_fail++; $display("FAIL invw_ack: d=%b i=%b sinv=%b exp 1/0/0", d_ack_o, i_ack_o, s_inv_o); end
    model_favor_d = 1'b0;
    step();
    s_ack_i = 1'b0; d_req_i = 1'b0; #1;
    n_checks++; if (s_req_o !== 1'b0 || s_inv_o !== 1'b0 || inv_busy_o !== 1'b1) begin n_fail++; $display("FAIL invw_idle: sreq=%b sinv=%b busy=%b exp 0/0/1", s_req_o, s_inv_o, inv_busy_o); end
    step(); #1;
    n_checks++; if (s_inv_o !== 1'b1 || s_req_o !== 1'b0) begin n_fail++; $display("FAIL invw_inv: sinv=%b sreq=%b exp 1/0", s_inv_o, s_req_o); end
    step(); #1;
    n_checks++; if (s_inv_o !== 1'b0 || s_req_o !== 1'b0 || inv_busy_o !== 1'b0) begin n_fail++; $display("FAIL invw_post: sinv=%b sreq=%b busy=%b exp 0/0/0", s_inv_o, s_req_o, inv_busy_o); end
    step(); #1;
    n_checks++; if (s_req_o !== 1'b1 || s_addr_o !== ia) begin n_fail++; $display("FAIL invw_igrant: sreq=%b addr=%h exp 1/%h", s_req_o, s_addr_o, ia); end
    step();
    s_ack_i = 1'b1; #1;
    n_checks++; if (i_ack_o !== 1'b1) begin n_fail++; $display("FAIL invw_iack: got %b exp 1", i_ack_o); end
    model_favor_d = 1'b1;
    step();
    s_ack_i = 1'b0; i_req_i = 1'b0;
    step();
  endtask

  task automatic test_merged_inv();
    int inv_seen;
    inv_seen = 0;
    d_req_i = 1'b1; d_addr_i = AW'($urandom); d_wstrb_i = '0;
    step();
    for (int g = 0; g < 8; g++) begin
      inv_i = (g == 0 || g == 2 || g == 4);
      #1;
      if (s_inv_o) inv_seen++;
      if (g > 0) begin
        n_checks++; if (inv_busy_o !== 1'b1) begin n_fail++; $display("FAIL merge_busy[%0d]: got %b exp 1", g, inv_busy_o); end
      end
      step();
    end
    inv_i = 1'b0; s_ack_i = 1'b1; #1;
    if (s_inv_o) inv_seen++;
    n_checks++; if (d_ack_o !== 1'b1 || inv_busy_o !== 1'b1) begin n_fail++; $display("FAIL merge_ack: dack=%b busy=%b exp 1/1", d_ack_o, inv_busy_o); end
    model_favor_d = 1'b0;
    step();
    s_ack_i = 1'b0; d_req_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (s_inv_o) inv_seen++;
      if (c < 2) begin
        n_checks++; if (inv_busy_o !== 1'b1) begin n_fail++; $display("FAIL merge_busy_tail[%0d]: got %b exp 1", c, inv_busy_o); end
      end else begin
        n_checks++; if (inv_busy_o !== 1'b0) begin n_fail++; $display("FAIL merge_busy_end[%0d]: got %b exp 0", c, inv_busy_o); end
      end
      step();
    end
    n_checks++; if (inv_seen != 1) begin n_fail++; $display("FAIL merge_count: got %0d invalidates exp 1", inv_seen); end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] da;
    i_req_i = 1'b1; i_addr_i = AW'($urandom);
    step(); #1;
    n_checks++; if (s_req_o !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: sreq got %b exp 1", s_req_o); end
    inv_i = 1'b1;
    step(); inv_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; s_ack_i = 1'b1; #1;
    n_checks++; if (s_req_o !== 1'b0 || i_ack_o !== 1'b0 || d_ack_o !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: sreq=%b iack=%b dack=%b exp 0/0/0", s_req_o, i_ack_o, d_ack_o); end
    n_checks++; if (inv_busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b exp 0", inv_busy_o); end
    model_favor_d = 1'b1;
    s_ack_i = 1'b0; i_req_i = 1'b0;
    step();
    da = AW'($urandom);
    i_req_i = 1'b1; d_req_i = 1'b1; d_addr_i = da;
    step(); #1;
    n_checks++; if (s_addr_o !== da) begin n_fail++; $display("FAIL rmid_ptr: addr got %h exp %h", s_addr_o, da); end
    s_ack_i = 1'b1; #1;
    model_favor_d = 1'b0;
    step();
    s_ack_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0;
    step();
  endtask

  task automatic test_cke();
    logic [AW-1:0] da;
    logic [AW-1:0] ia;
    bit wd;
    da = AW'($urandom); ia = AW'($urandom);
    d_req_i = 1'b1; d_addr_i = da;
    step(); #1;
    n_checks++; if (s_req_o !== 1'b1 || s_addr_o !== da) begin n_fail++; $display("FAIL cke_gnt: sreq=%b addr=%h exp 1/%h", s_req_o, s_addr_o, da); end
    cke_i = 1'b0; i_req_i = 1'b1; i_addr_i = ia;
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      n_checks++; if (s_req_o !== 1'b1 || s_addr_o !== da || d_ack_o !== 1'b0) begin n_fail++; $display("FAIL cke_hold[%0d]: sreq=%b addr=%h dack=%b exp 1/%h/0", c, s_req_o, s_addr_o, d_ack_o, da); end
    end
    cke_i = 1'b1; s_ack_i = 1'b1; #1;
    n_checks++; if (d_ack_o !== 1'b1) begin n_fail++; $display("FAIL cke_resume: dack got %b exp 1", d_ack_o); end
    model_favor_d = 1'b0;
    step();
    s_ack_i = 1'b0; d_req_i = 1'b1;
    wd = model_pick_d(1'b1, 1'b1);
    step(); #1;
    n_checks++; if (s_addr_o !== (wd ? da : ia)) begin n_fail++; $display("FAIL cke_next: addr got %h exp %h", s_addr_o, wd ? da : ia); end
    s_ack_i = 1'b1; #1;
    model_favor_d = !wd;
    step();
    s_ack_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_random();
    test_inv_idle();
    test_inv_during_write();
    test_merged_inv();
    test_reset_mid();
    test_cke();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
